// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage core.
// Contents:
//   DEFAULT_XLEN / DEFAULT_RAW : default datapath and register-address widths
//   alu_code_e                 : shared ALUCode encoding consumed by the EX-stage ALU
//   SRC_A_* / SRC_B_*          : operand source selector encodings used by ID/EX
package cpu_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam int DEFAULT_RAW  = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_LUI  = 4'b0010,
    ALU_AND  = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLT  = 4'b1001,
    ALU_SLTU = 4'b1010
  } alu_code_e;

  // Operand-A source; encoding 3 is reserved and behaves like SRC_A_ZERO.
  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  // Operand-B source.
  localparam logic SRC_B_RS2 = 1'b0;
  localparam logic SRC_B_IMM = 1'b1;

endpackage

// File: rtl/ex_fwd_unit.sv
// Combinational forwarding comparator/mux for one EX-stage source operand.
// Ports:
//   mem_reg_write, mem_rd_addr, mem_alu_result : producer currently in EX/MEM
//   wb_reg_write, wb_rd_addr, wb_data          : producer currently in MEM/WB
//   rs_addr, rs_data                           : registered source index and value
//   fwd_data                                   : newest value of that source
// The younger EX/MEM producer wins over MEM/WB; register x0 never forwards.
module ex_fwd_unit
  import cpu_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN,
  parameter int RAW  = DEFAULT_RAW
) (
  input  logic            mem_reg_write,
  input  logic [RAW-1:0]  mem_rd_addr,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic            wb_reg_write,
  input  logic [RAW-1:0]  wb_rd_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic [RAW-1:0]  rs_addr,
  input  logic [XLEN-1:0] rs_data,
  output logic [XLEN-1:0] fwd_data
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs_addr);
  assign wb_hit  = wb_reg_write  && (wb_rd_addr  != '0) && (wb_rd_addr  == rs_addr);

  always_comb begin
    fwd_data = rs_data;
    if (mem_hit) begin
      fwd_data = mem_alu_result;
    end else if (wb_hit) begin
      fwd_data = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the EX-stage ALU.
// Ports:
//   clk, reset                      : clock and synchronous active-high reset
//   stall, flush                    : hold / bubble controls from the hazard unit
//   id_*                            : decoded instruction fields from ID
//   mem_reg_write/rd_addr/alu_result: EX/MEM producer used for forwarding
//   wb_reg_write/rd_addr/data       : MEM/WB producer used for forwarding and
//                                     same-cycle register-file bypass
//   alu_a, alu_b, alu_code          : ALU operands and operation
//   ex_store_data                   : forwarded rs2 for stores
//   ex_valid, ex_pc, ex_rd_addr,
//   ex_reg_write, ex_mem_read,
//   ex_mem_write                    : registered copies of ID fields
//   load_use_hazard                 : combinational stall request to ID/IF
// Edge priority: reset > flush > stall > load.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN,
  parameter int RAW  = DEFAULT_RAW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [RAW-1:0]  id_rs1_addr,
  input  logic [RAW-1:0]  id_rs2_addr,
  input  logic [RAW-1:0]  id_rd_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_alu_code,
  input  logic [1:0]      id_alu_src_a,
  input  logic            id_alu_src_b,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            mem_reg_write,
  input  logic [RAW-1:0]  mem_rd_addr,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic            wb_reg_write,
  input  logic [RAW-1:0]  wb_rd_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_code,
  output logic [XLEN-1:0] ex_store_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [RAW-1:0]  ex_rd_addr,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            load_use_hazard
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [RAW-1:0]  rs1_addr;
    logic [RAW-1:0]  rs2_addr;
    logic [RAW-1:0]  rd_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_code;
    logic [1:0]      src_a;
    logic            src_b;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } ex_fields_t;

  ex_fields_t ex_reg;
  ex_fields_t ex_next;

  // Index 0 = rs1, index 1 = rs2.
  logic [RAW-1:0]  rs_addr  [2];
  logic [XLEN-1:0] rs_data  [2];
  logic [XLEN-1:0] fwd_data [2];

  assign rs_addr[0] = ex_reg.rs1_addr;
  assign rs_addr[1] = ex_reg.rs2_addr;
  assign rs_data[0] = ex_reg.rs1_data;
  assign rs_data[1] = ex_reg.rs2_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      ex_fwd_unit #(
        .XLEN(XLEN),
        .RAW (RAW)
      ) u_fwd (
        .mem_reg_write (mem_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .mem_alu_result(mem_alu_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_data       (wb_data),
        .rs_addr       (rs_addr[gi]),
        .rs_data       (rs_data[gi]),
        .fwd_data      (fwd_data[gi])
      );
    end
  endgenerate

  // The register file is written at the end of the cycle it is read, so a
  // MEM/WB write to the register ID is reading must be taken from wb_data.
  logic wb_byp_rs1;
  logic wb_byp_rs2;

  assign wb_byp_rs1 = wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == id_rs1_addr);
  assign wb_byp_rs2 = wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == id_rs2_addr);

  always_comb begin
    ex_next = ex_reg;
    if (flush) begin
      ex_next = '0;
    end else if (stall) begin
      // Keep refreshing the operands while held: a producer that leaves WB
      // during the stall would otherwise no longer be visible to forwarding.
      ex_next.rs1_data = fwd_data[0];
      ex_next.rs2_data = fwd_data[1];
    end else begin
      ex_next.valid     = id_valid;
      ex_next.pc        = id_pc;
      ex_next.rs1_addr  = id_rs1_addr;
      ex_next.rs2_addr  = id_rs2_addr;
      ex_next.rd_addr   = id_rd_addr;
      ex_next.rs1_data  = wb_byp_rs1 ? wb_data : id_rs1_data;
      ex_next.rs2_data  = wb_byp_rs2 ? wb_data : id_rs2_data;
      ex_next.imm       = id_imm;
      ex_next.alu_code  = id_alu_code;
      ex_next.src_a     = id_alu_src_a;
      ex_next.src_b     = id_alu_src_b;
      ex_next.reg_write = id_reg_write;
      ex_next.mem_read  = id_mem_read;
      ex_next.mem_write = id_mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_reg <= '0;
    end else begin
      ex_reg <= ex_next;
    end
  end

  // Operand selection; the reserved src_a encoding yields zero.
  always_comb begin
    case (ex_reg.src_a)
      SRC_A_RS1: alu_a = fwd_data[0];
      SRC_A_PC:  alu_a = ex_reg.pc;
      default:   alu_a = '0;
    endcase
  end

  assign alu_b         = (ex_reg.src_b == SRC_B_IMM) ? ex_reg.imm : fwd_data[1];
  assign ex_store_data = fwd_data[1];

  assign alu_code     = ex_reg.alu_code;
  assign ex_valid     = ex_reg.valid;
  assign ex_pc        = ex_reg.pc;
  assign ex_rd_addr   = ex_reg.rd_addr;
  assign ex_reg_write = ex_reg.reg_write;
  assign ex_mem_read  = ex_reg.mem_read;
  assign ex_mem_write = ex_reg.mem_write;

  // Conservative: both ID sources are compared even if rs2 is unused.
  assign load_use_hazard = ex_reg.valid && ex_reg.mem_read && (ex_reg.rd_addr != '0) &&
                           ((ex_reg.rd_addr == id_rs1_addr) || (ex_reg.rd_addr == id_rs2_addr)) &&
                           id_valid;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage core; sits directly upstream of the EX-stage ALU and feeds its A, B and ALUCode inputs.
- Latches decoded fields from ID.
- Applies MEM/WB forwarding to the operands and selects each ALU source.
- Holds under stall, inserts bubbles on flush, and flags load-use hazards back to the hazard/PC logic.

Parameters:
XLEN, 32, datapath width
RAW, 5, register address width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hold EX contents this cycle
flush  in  1  replace EX contents with a bubble
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rs1_addr, id_rs2_addr, id_rd_addr  in  RAW each  register indices
id_rs1_data, id_rs2_data  in  XLEN each  register-file read data
id_imm  in  XLEN  sign-extended immediate
id_alu_code  in  4  ALU operation, using the shared ALUCode encoding
id_alu_src_a  in  2  operand-A source: 0 = rs1, 1 = pc, 2 = zero, 3 = reserved (treated as zero)
id_alu_src_b  in  1  operand-B source: 0 = rs2, 1 = imm
id_reg_write, id_mem_read, id_mem_write  in  1 each  control
mem_reg_write  in  1  EX/MEM instruction writes rd
mem_rd_addr  in  RAW  EX/MEM destination
mem_alu_result  in  XLEN  EX/MEM result
wb_reg_write  in  1  MEM/WB writes rd
wb_rd_addr  in  RAW  MEM/WB destination
wb_data  in  XLEN  MEM/WB write-back value
alu_a, alu_b  out  XLEN  ALU operands
alu_code  out  4  registered id_alu_code
ex_store_data  out  XLEN  forwarded rs2 for stores
ex_valid, ex_pc, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write  out  registered copies
load_use_hazard  out  1  combinational stall request to ID/IF

Behaviour:
Interface:
- One clock, clk; reset is synchronous and active-high, named reset.

Update priority each rising edge: reset > flush > stall > load.
- reset: every register cleared to 0, including ex_valid, all controls, alu_code (= add, 4'b0000), rd_addr, pc, rs data and imm.
  - Outputs read 0 until the first load.
  - Reset asserted mid-stall or mid-hazard discards the held instruction.
- flush: inserts a bubble.
  - ex_valid, ex_reg_write, ex_mem_read and ex_mem_write become 0; other fields are don't-care but driven 0.
  - Flush while stall still inserts the bubble.
- stall (no flush): every field held, except the rs1/rs2 data registers, which reload with the currently forwarded operand values (fwd_rs1 / fwd_rs2).
  - Required so a producer leaving WB during the stall is not lost.
- load: all fields captured from ID; latency exactly 1 cycle.
  - If wb_reg_write, wb_rd_addr != 0 and wb_rd_addr == id_rsN_addr, capture wb_data instead of id_rsN_data (register-file write/read same cycle).

Forwarding (combinational from registered state):
- fwd_rsN = mem_alu_result if mem_reg_write & mem_rd_addr != 0 & mem_rd_addr == ex_rsN_addr.
- Else wb_data if wb_reg_write & wb_rd_addr != 0 & wb_rd_addr == ex_rsN_addr.
- Else the registered rsN data.
- MEM beats WB when both match. x0 never forwards.

Operand selection:
- alu_a = fwd_rs1 / ex_pc / 0 per registered src_a.
- alu_b = fwd_rs2 or ex_imm per registered src_b.
- ex_store_data = fwd_rs2 always.

Load-use hazard:
- load_use_hazard = ex_valid & ex_mem_read & ex_rd_addr != 0 & (ex_rd_addr == id_rs1_addr | ex_rd_addr == id_rs2_addr) & id_valid.
- Conservative: it ignores whether ID actually uses rs2.
- The hazard unit responds with flush of this stage plus stall of IF/ID; this block does not self-flush.

No arithmetic is performed here. Widths pass through unchanged.

Decomposition:
- Shared package cpu_pkg:
  - ALUCode constants: add 0000, sub 0001, lui 0010, and 0011, xor 0100, or 0101, sll 0110, srl 0111, sra 1000, slt 1001, sltu 1010.
  - SRC_A_RS1/PC/ZERO and SRC_B_RS2/IMM constants.
  - XLEN and RAW defaults.
- One sub-module: ex_fwd_unit, the combinational forwarding comparator/mux for one operand, instantiated twice (rs1, rs2).

Test Plan:
- Reset: hold reset 2 cycles with random ID inputs -> all outputs 0 and alu_code = 0000. Release with id add x3,x1,x2 (x1 = 5, x2 = 7) -> next cycle alu_a = 5, alu_b = 7, ex_reg_write = 1.
- Forward priority: EX holds rs1 = x4; mem rd = x4 with result 0x11, wb rd = x4 with data 0x22 -> alu_a = 0x11. Drop mem_reg_write -> alu_a = 0x22. Set rd = x0 on both -> alu_a = raw register value.
- Source select: src_a = pc (pc = 0x100), src_b = imm (imm = 0xFFFFFFFC), alu_code = 0000 -> alu_a = 0x100, alu_b = 0xFFFFFFFC, ex_store_data = fwd rs2.
- Stall retention: EX holds rs2 = x6; WB writes x6 = 0xABCD; assert stall 3 cycles while WB moves on -> alu_b stays 0xABCD throughout and after stall release.
- Load-use: EX holds lw x5 (ex_mem_read = 1), ID rs1 = x5 -> load_use_hazard = 1. ID rs1 = x0 with EX rd = x0 -> 0. Flush + stall together -> next cycle ex_valid = 0, all write/mem controls 0.
- WB same-cycle capture: load with id_rs1 = x9 while WB writes x9 = 0x77 and id_rs1_data stale = 0 -> next cycle alu_a = 0x77 after WB retires.
